ws2812_ring_engine: RTL and testbench

Parametrised successor to the fixed 12-LED ring driver. It serialises a mask-based frame for a WS2812B chain of any length and any bit-timing, with rotational offset, a frame-done strobe and optional queuing of refresh requests. It sits between the ring controller (mask, colour, intensity, refresh) and the `led_dout` pad.

---
 rtl/ws2812_ring_engine_if.sv | 25 ++
 rtl/ws2812_ring_engine.sv | 190 +++++++++++++++++++
 tb/tb_ws2812_ring_engine.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/ws2812_ring_engine_if.sv
// Control/status bundle between the ring controller (master) and the WS2812B engine (slave).
interface ws2812_ring_engine_if #(
    parameter int NUM_LEDS = 12
);
    localparam int OW = $clog2(NUM_LEDS);

    logic                refresh;
    logic [NUM_LEDS-1:0] led_mask;
    logic [OW-1:0]       offset;
    logic [2:0]          colour;
    logic [7:0]          intensity;
    logic                led_dout;
    logic                busy;
    logic                frame_done;

    modport master (
        output refresh, led_mask, offset, colour, intensity,
        input  led_dout, busy, frame_done
    );

    modport slave (
        input  refresh, led_mask, offset, colour, intensity,
        output led_dout, busy, frame_done
    );
endinterface

// File: rtl/ws2812_ring_engine.sv
// Serialises a rotated, mask-based GRB frame onto a WS2812B chain followed by a latch gap.
// Define WS_RING_REFRESH_QUEUE_EN to queue one refresh request raised while a frame is in flight.
module ws2812_ring_engine #(
    parameter int NUM_LEDS = 12,
    parameter int T0H      = 20,
    parameter int T1H      = 40,
    parameter int TBIT     = 62,
    parameter int TRES     = 2600
) (
    input  logic                 clk,
    input  logic                 res,
    ws2812_ring_engine_if.slave  bus
);
    localparam int OW = $clog2(NUM_LEDS);
    localparam int CW = $clog2(TBIT);
    localparam int GW = (TRES > 1) ? $clog2(TRES) : 1;

    localparam logic [OW:0]   N_W      = (OW+1)'(NUM_LEDS);
    localparam logic [OW-1:0] LED_LAST = OW'(NUM_LEDS - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TBIT - 1);
    localparam logic [CW-1:0] T0H_W    = CW'(T0H);
    localparam logic [CW-1:0] T1H_W    = CW'(T1H);
    localparam logic [GW-1:0] GAP_LAST = GW'(TRES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [OW-1:0]       led_q, led_d;
    logic [4:0]          bit_q, bit_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [GW-1:0]       gap_q, gap_d;
    logic [23:0]         word_q, word_d;
    logic [NUM_LEDS-1:0] mask_q, mask_d;
    logic [OW-1:0]       off_q, off_d;
    logic [2:0]          col_q, col_d;
    logic [7:0]          int_q, int_d;
    logic                dout_q, dout_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                start;
    logic [OW-1:0]       off_in;
`ifdef WS_RING_REFRESH_QUEUE_EN
    logic                pending_q, pending_d;
`endif

    // Physical LED p shows logical LED (p + offset) mod NUM_LEDS; both operands are < NUM_LEDS.
    function automatic logic lit_of(input logic [NUM_LEDS-1:0] mask,
                                    input logic [OW-1:0] p,
                                    input logic [OW-1:0] off);
        logic [OW:0] sum;
        sum = {1'b0, p} + {1'b0, off};
        if (sum >= N_W) begin
            sum = sum - N_W;
        end
        return mask[sum[OW-1:0]];
    endfunction

    function automatic logic [23:0] grb_word(input logic lit,
                                             input logic [2:0] col,
                                             input logic [7:0] inten);
        logic [7:0] g, r, b;
        g = (lit && col[1]) ? inten : 8'h00;
        r = (lit && col[2]) ? inten : 8'h00;
        b = (lit && col[0]) ? inten : 8'h00;
        return {g, r, b};
    endfunction

    assign off_in = ({1'b0, bus.offset} >= N_W) ? '0 : bus.offset;

    always_comb begin
        state_d = state_q;
        led_d   = led_q;
        bit_d   = bit_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        word_d  = word_q;
        mask_d  = mask_q;
        off_d   = off_q;
        col_d   = col_q;
        int_d   = int_q;
        start   = 1'b0;
`ifdef WS_RING_REFRESH_QUEUE_EN
        pending_d = pending_q;
        if (state_q != S_IDLE && bus.refresh) begin
            pending_d = 1'b1;
        end
`endif

        case (state_q)
            S_IDLE: start = bus.refresh;
            S_SEND: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (bit_q == 5'd0) begin
                        if (led_q == LED_LAST) begin
                            state_d = S_GAP;
                            gap_d   = '0;
                        end else begin
                            led_d  = led_q + OW'(1);
                            bit_d  = 5'd23;
                            word_d = grb_word(lit_of(mask_q, led_q + OW'(1), off_q), col_q, int_q);
                        end
                    end else begin
                        bit_d  = bit_q - 5'd1;
                        word_d = {word_q[22:0], 1'b0};
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = S_IDLE;
`ifdef WS_RING_REFRESH_QUEUE_EN
                    start = pending_q | bus.refresh;
`endif
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Snapshot the request and preload LED 0's word so the first bit leaves on the next edge.
        if (start) begin
            state_d = S_SEND;
            mask_d  = bus.led_mask;
            off_d   = off_in;
            col_d   = bus.colour;
            int_d   = bus.intensity;
            led_d   = '0;
            bit_d   = 5'd23;
            cnt_d   = '0;
            word_d  = grb_word(lit_of(bus.led_mask, OW'(0), off_in), bus.colour, bus.intensity);
`ifdef WS_RING_REFRESH_QUEUE_EN
            pending_d = 1'b0;
`endif
        end

        done_d = (state_d == S_GAP) && (gap_d == GAP_LAST);
        busy_d = (state_d != S_IDLE);
        dout_d = (state_d == S_SEND) && (cnt_d < (word_d[23] ? T1H_W : T0H_W));
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q <= S_IDLE;
            led_q   <= '0;
            bit_q   <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
            word_q  <= '0;
            mask_q  <= '0;
            off_q   <= '0;
            col_q   <= '0;
            int_q   <= '0;
            dout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef WS_RING_REFRESH_QUEUE_EN
            pending_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            led_q   <= led_d;
            bit_q   <= bit_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            word_q  <= word_d;
            mask_q  <= mask_d;
            off_q   <= off_d;
            col_q   <= col_d;
            int_q   <= int_d;
            dout_q  <= dout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef WS_RING_REFRESH_QUEUE_EN
            pending_q <= pending_d;
`endif
        end
    end

    assign bus.led_dout   = dout_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = done_q;
endmodule

// File: tb/tb_ws2812_ring_engine.sv
// Bench for ws2812_ring_engine: randomized frames checked cycle by cycle against a waveform model.
module tb_ws2812_ring_engine;
    localparam int N     = 4;
    localparam int T0    = 2;
    localparam int T1    = 4;
    localparam int TB    = 6;
    localparam int TR    = 10;
    localparam int SENDC = 24 * N * TB;
    localparam int FRAME = SENDC + TR;

    logic clk = 1'b0;
    logic res = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    ws2812_ring_engine_if #(.NUM_LEDS(N)) bus ();

    ws2812_ring_engine #(
        .NUM_LEDS(N), .T0H(T0), .T1H(T1), .TBIT(TB), .TRES(TR)
    ) dut (
        .clk(clk),
        .res(res),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Expected led_dout in cycle c (1 = first cycle after the accepting edge).
    function automatic logic exp_dout(input int c, input logic [3:0] m, input int off,
                                      input logic [2:0] cl, input logic [7:0] it);
        int idx, b, t, p, w, o;
        logic lit, chan, v;
        logic [7:0] by;
        idx = c - 1;
        if (idx < 0 || idx >= SENDC) return 1'b0;
        b = idx / TB;
        t = idx % TB;
        p = b / 24;
        w = b % 24;
        o = (off >= N) ? 0 : off;
        lit = m[(p + o) % N];
        if (w < 8)       chan = cl[1];
        else if (w < 16) chan = cl[2];
        else             chan = cl[0];
        by = (lit && chan) ? it : 8'h00;
        v = by[7 - (w % 8)];
        return (t < (v ? T1 : T0));
    endfunction

    task automatic send_request(input logic [3:0] m, input int off,
                                input logic [2:0] cl, input logic [7:0] it);
        bus.led_mask  = m;
        bus.offset    = 2'(off);
        bus.colour    = cl;
        bus.intensity = it;
        bus.refresh   = 1'b1;
        @(negedge clk);
        bus.refresh   = 1'b0;
    endtask

    task automatic check_frame(input string name, input logic [3:0] m, input int off,
                               input logic [2:0] cl, input logic [7:0] it,
                               input bit scramble, input bit pulses);
        int derr, berr, ferr, dfirst;
        logic e, dgot, dwant;
        derr = 0; berr = 0; ferr = 0; dfirst = 0; dgot = 0; dwant = 0;
        for (int c = 1; c <= FRAME; c++) begin
            e = exp_dout(c, m, off, cl, it);
            if (bus.led_dout !== e) begin
                if (derr == 0) begin
                    dfirst = c; dgot = bus.led_dout; dwant = e;
                end
                derr++;
            end
            if (bus.busy !== 1'b1) berr++;
            if (bus.frame_done !== (c == FRAME)) ferr++;
            if (scramble && c == 100) begin
                bus.led_mask  = 4'($urandom);
                bus.offset    = 2'($urandom);
                bus.colour    = 3'($urandom);
                bus.intensity = 8'($urandom);
            end
            if (pulses) bus.refresh = (c == 578 || c == 580 || c == 582);
            if (c < FRAME) @(negedge clk);
        end
        bus.refresh = 1'b0;
        checks += 3;
        if (derr != 0) begin
            failures++;
            $display("FAIL %s dout: %0d bad cycles, first at cycle %0d got %b want %b",
                     name, derr, dfirst, dgot, dwant);
        end
        if (berr != 0) begin
            failures++;
            $display("FAIL %s busy: %0d cycles low, want high for all %0d", name, berr, FRAME);
        end
        if (ferr != 0) begin
            failures++;
            $display("FAIL %s frame_done: %0d bad cycles, want high only at cycle %0d",
                     name, ferr, FRAME);
        end
        $display("frame %s mask=%b off=%0d col=%b int=%h dout_err=%0d busy_err=%0d done_err=%0d",
                 name, m, off, cl, it, derr, berr, ferr);
    endtask

    task automatic check_idle(input string name, input int cycles);
        int bad;
        bad = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.busy !== 1'b0 || bus.led_dout !== 1'b0 || bus.frame_done !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL %s idle: %0d of %0d cycles active (busy=%b dout=%b done=%b), want all 0",
                     name, bad, cycles, bus.busy, bus.led_dout, bus.frame_done);
        end
        $display("idle %s cycles=%0d active=%0d", name, cycles, bad);
    endtask

    task automatic test_reset();
        bus.refresh = 1'b0; bus.led_mask = '0; bus.offset = '0; bus.colour = '0; bus.intensity = '0;
        res = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.led_dout !== 1'b0 || bus.busy !== 1'b0 || bus.frame_done !== 1'b0) begin
            failures++;
            $display("FAIL reset outputs: got dout=%b busy=%b done=%b want 0 0 0",
                     bus.led_dout, bus.busy, bus.frame_done);
        end
        $display("reset dout=%b busy=%b done=%b", bus.led_dout, bus.busy, bus.frame_done);
        res = 1'b0;
        check_idle("after_reset", 3);
    endtask

    task automatic test_basic();
        send_request(4'b0001, 0, 3'b100, 8'hA5);
        check_frame("basic", 4'b0001, 0, 3'b100, 8'hA5, 0, 0);
        check_idle("basic_end", 3);
    endtask

    task automatic test_offset();
        send_request(4'b0001, 1, 3'b100, 8'hA5);
        check_frame("offset1", 4'b0001, 1, 3'b100, 8'hA5, 0, 0);
        check_idle("offset1_end", 2);
        send_request(4'b0110, 3, 3'b011, 8'h3C);
        check_frame("offset3", 4'b0110, 3, 3'b011, 8'h3C, 0, 0);
        check_idle("offset3_end", 2);
    endtask

    task automatic test_random();
        logic [3:0] m;
        logic [2:0] cl;
        logic [7:0] it;
        int off;
        for (int i = 0; i < 3; i++) begin
            m   = 4'($urandom);
            off = $urandom_range(0, N - 1);
            cl  = 3'($urandom);
            it  = (i == 2) ? 8'h00 : 8'($urandom);
            send_request(m, off, cl, it);
            check_frame($sformatf("rand%0d", i), m, off, cl, it, 0, 0);
            check_idle($sformatf("rand%0d_end", i), 2);
        end
    endtask

    task automatic test_snapshot();
        send_request(4'b1011, 2, 3'b111, 8'h5A);
        check_frame("snapshot", 4'b1011, 2, 3'b111, 8'h5A, 1, 0);
        check_idle("snapshot_end", 2);
    endtask

    task automatic test_gap_refresh();
        logic [3:0] m2;
        logic [2:0] cl2;
        logic [7:0] it2;
        int off2;
        m2 = 4'($urandom) | 4'b0001; off2 = $urandom_range(0, N - 1);
        cl2 = 3'($urandom) | 3'b001; it2 = 8'($urandom) | 8'h01;
        send_request(4'b1100, 0, 3'b010, 8'hC3);
        bus.led_mask = m2; bus.offset = 2'(off2); bus.colour = cl2; bus.intensity = it2;
        check_frame("gap_first", 4'b1100, 0, 3'b010, 8'hC3, 0, 1);
`ifdef WS_RING_REFRESH_QUEUE_EN
        @(negedge clk);
        check_frame("gap_queued", m2, off2, cl2, it2, 0, 0);
        check_idle("gap_queued_end", 8);
`else
        check_idle("gap_no_queue", 8);
`endif
    endtask

    task automatic test_reset_mid();
        send_request(4'b1111, 0, 3'b111, 8'hFF);
        repeat (180) @(negedge clk);
        res = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.led_dout !== 1'b0 || bus.busy !== 1'b0 || bus.frame_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid outputs: got dout=%b busy=%b done=%b want 0 0 0",
                     bus.led_dout, bus.busy, bus.frame_done);
        end
        $display("reset_mid dout=%b busy=%b", bus.led_dout, bus.busy);
        bus.refresh = 1'b1;
        @(negedge clk);
        res = 1'b0;
        bus.refresh = 1'b0;
        check_idle("refresh_in_reset", 3);
        send_request(4'b0101, 1, 3'b101, 8'h96);
        check_frame("after_reset_mid", 4'b0101, 1, 3'b101, 8'h96, 0, 0);
        check_idle("after_reset_mid_end", 2);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_offset();
        test_random();
        test_snapshot();
        test_gap_refresh();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
